rst_seq_ctrl: RTL and testbench

Reset sequencer for the async-clear/preset flop population. It asserts all downstream resets immediately on `clr`, synchronises the release to `clk`, and deasserts `NUM_OUT` reset domains one at a time with a fixed gap. It also supports a handshaked soft-reset request that replays the same sequence. It sits at the top of each test design and drives the `clr`/`pre` pins of the flop instances it controls.

---
 rtl/rst_seq_pkg.sv | 16 +
 rtl/rst_sync.sv | 23 ++
 rtl/rst_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_rst_seq_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Reset sequencer shared types and default parameters.
// Imported by the sequencer top-level.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    RELEASE   = 2'd1,
    RUN       = 2'd2,
    SOFT_HOLD = 2'd3
  } rst_seq_state_t;

  localparam int DEF_NUM_OUT     = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_GAP_CYCLES  = 8;

endpackage

// File: rtl/rst_sync.sv
// Async-assert / sync-release chain.
// sync_ok rises STAGES edges after clr drops.
module rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  output logic sync_ok
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], 1'b1};
    end
  end

  assign sync_ok = sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Sequenced reset controller: staggered domain release
// after clr or a handshaked soft-reset request.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_OUT     = DEF_NUM_OUT,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int CNT_W       = $clog2(GAP_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               soft_req,
  output logic               soft_ack,
  output logic [NUM_OUT-1:0] rst_out,
  output logic [NUM_OUT-1:0] rst_out_n,
  output logic               done
);

  localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [CNT_W-1:0] GAP_M1 = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_OUT - 1);

  rst_seq_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NUM_OUT-1:0] rst_q, rst_d;
  logic [NUM_OUT-1:0] rst_n_q;
  logic done_q, done_d;
  logic ack_q, ack_d;
  logic soft_q, soft_d;
  logic sync_ok;

  rst_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .clr     (clr),
    .sync_ok (sync_ok)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      soft_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      rst_n_q <= ~rst_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      soft_q  <= soft_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    done_d  = done_q;
    ack_d   = ack_q;
    soft_d  = soft_q;
    unique case (state_q)
      HOLD: begin
        rst_d  = '1;
        done_d = 1'b0;
        if (sync_ok) begin
          state_d = RELEASE;
          idx_d   = '0;
          cnt_d   = GAP_M1;
        end
      end
      RELEASE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          for (int k = 0; k < NUM_OUT; k++) begin
            if (idx_q == IDX_W'(k)) rst_d[k] = 1'b0;
          end
          cnt_d = GAP_M1;
          idx_d = idx_q + IDX_W'(1);
          // ack only ends a sequence that a soft request started
          if (idx_q == LAST) begin
            state_d = RUN;
            done_d  = 1'b1;
            ack_d   = soft_q;
            soft_d  = 1'b0;
          end
        end
      end
      RUN: begin
        if (soft_req && !ack_q) begin
          state_d = SOFT_HOLD;
          rst_d   = '1;
          done_d  = 1'b0;
          cnt_d   = GAP_M1;
          soft_d  = 1'b1;
        end else if (!soft_req && ack_q) begin
          ack_d = 1'b0;
        end
      end
      SOFT_HOLD: begin
        rst_d = '1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = RELEASE;
          idx_d   = '0;
          cnt_d   = GAP_M1;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  assign rst_out   = rst_q;
  assign rst_out_n = rst_n_q;
  assign done      = done_q;
  assign soft_ack  = ack_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: default and
// minimal-parameter instances checked per output event.
module tb_rst_seq_ctrl;

  typedef struct {
    int         cyc;
    logic [5:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic clr0, clr1, soft0, soft1;
  logic ack0, ack1, done0, done1;
  logic [3:0] ro0, ron0;
  logic [0:0] ro1, ron1;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  exp_t q[2][$];
  logic [5:0] last [2] = '{6'h3f, 6'h3f};
  logic [5:0] snap [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rst_seq_ctrl u_dut0 (
    .clk       (clk),
    .clr       (clr0),
    .soft_req  (soft0),
    .soft_ack  (ack0),
    .rst_out   (ro0),
    .rst_out_n (ron0),
    .done      (done0)
  );

  rst_seq_ctrl #(
    .NUM_OUT     (1),
    .SYNC_STAGES (2),
    .GAP_CYCLES  (1)
  ) u_dut1 (
    .clk       (clk),
    .clr       (clr1),
    .soft_req  (soft1),
    .soft_ack  (ack1),
    .rst_out   (ro1),
    .rst_out_n (ron1),
    .done      (done1)
  );

  // Monitor: every output change pops one expected event
  always @(negedge clk) begin
    exp_t e;
    snap[0] = {ro0, done0, ack0};
    snap[1] = {3'b000, ro1, done1, ack1};
    n_chk += 2;
    if (ron0 !== ~ro0) begin
      n_fail++;
      $display("FAIL inv0 cyc %0d: rst_out_n %b, need %b",
               cyc, ron0, ~ro0);
    end
    if (ron1 !== ~ro1) begin
      n_fail++;
      $display("FAIL inv1 cyc %0d: rst_out_n %b, need %b",
               cyc, ron1, ~ro1);
    end
    for (int d = 0; d < 2; d++) begin
      if (snap[d] !== last[d]) begin
        last[d] = snap[d];
        n_chk++;
        if (q[d].size() == 0) begin
          n_fail++;
          $display("FAIL dut%0d spurious: got %b at cyc %0d",
                   d, snap[d], cyc);
        end else begin
          e = q[d].pop_front();
          if (e.v !== snap[d] ||
              (e.cyc >= 0 && e.cyc != cyc)) begin
            n_fail++;
            $display("FAIL dut%0d event: got %b @%0d, need %b @%0d",
                     d, snap[d], cyc, e.v, e.cyc);
          end
        end
      end else if (q[d].size() != 0 && q[d][0].cyc >= 0 &&
                   cyc > q[d][0].cyc) begin
        n_chk++;
        n_fail++;
        e = q[d].pop_front();
        $display("FAIL dut%0d missing: need %b @%0d, still %b",
                 d, e.v, e.cyc, snap[d]);
      end
    end
  end

  task automatic push(input int d, input int c,
                      input logic [5:0] v);
    exp_t e;
    e.cyc = c;
    e.v = v;
    q[d].push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic drain();
    while (q[0].size() != 0 || q[1].size() != 0) tick();
  endtask

  // v = {rst_out, done, soft_ack}
  task automatic push_pwr(input int e0);
    push(0, e0 + 11, 6'b1110_00);
    push(0, e0 + 19, 6'b1100_00);
    push(0, e0 + 27, 6'b1000_00);
    push(0, e0 + 35, 6'b0000_10);
  endtask

  task automatic push_soft(input int r);
    push(0, r,      6'b1111_00);
    push(0, r + 16, 6'b1110_00);
    push(0, r + 24, 6'b1100_00);
    push(0, r + 32, 6'b1000_00);
    push(0, r + 40, 6'b0000_11);
  endtask

  initial begin
    int e0;
    int r;
    clr0 = 1'b0;
    clr1 = 1'b0;
    soft0 = 1'b0;
    soft1 = 1'b0;
    push(0, -1, 6'b1111_00);
    push(1, -1, 6'b0001_00);
    #1;
    clr0 = 1'b1;
    clr1 = 1'b1;
    repeat (3) tick();

    // power-on release sequence
    clr0 = 1'b0;
    e0 = cyc;
    push_pwr(e0);
    drain();
    repeat (5) tick();

    // clr from RUN, then a short glitch at E23
    #1;
    push(0, cyc, 6'b1111_00);
    clr0 = 1'b1;
    #4;
    clr0 = 1'b0;
    e0 = cyc;
    push(0, e0 + 11, 6'b1110_00);
    push(0, e0 + 19, 6'b1100_00);
    wait_cyc(e0 + 23);
    #1;
    push(0, cyc, 6'b1111_00);
    clr0 = 1'b1;
    #4;
    clr0 = 1'b0;
    e0 = cyc;
    push_pwr(e0);
    drain();

    // soft reset, request held past ack
    tick();
    soft0 = 1'b1;
    r = cyc + 1;
    push_soft(r);
    wait_cyc(r + 45);
    soft0 = 1'b0;
    push(0, r + 46, 6'b0000_10);
    drain();
    repeat (3) tick();

    // request held through power-on is ignored until RUN
    #1;
    push(0, cyc, 6'b1111_00);
    soft0 = 1'b1;
    clr0 = 1'b1;
    #4;
    clr0 = 1'b0;
    e0 = cyc;
    push_pwr(e0);
    r = e0 + 36;
    push_soft(r);
    wait_cyc(r + 40);
    soft0 = 1'b0;
    push(0, r + 41, 6'b0000_10);
    drain();

    // minimal parameters: one domain, one-cycle gap
    #1;
    clr1 = 1'b0;
    e0 = cyc;
    push(1, e0 + 4, 6'b0000_10);
    drain();
    tick();
    soft1 = 1'b1;
    r = cyc + 1;
    push(1, r, 6'b0001_00);
    push(1, r + 2, 6'b0000_11);
    wait_cyc(r + 2);
    soft1 = 1'b0;
    push(1, r + 3, 6'b0000_10);
    drain();

    repeat (20) tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
